mcl86_bus_bridge: RTL and testbench
===================================

Name: mcl86_bus_bridge

Overview:
- Consumes the multiplexed 8088 minimum-mode bus produced by the CPU core and converts each bus cycle into a single-beat request/acknowledge transaction for memory/IO fabric.
- Latches the address on ALE and captures write data; returns read data and interrupt vectors on AD_IN.
- Paces the core through READY_IN and times out cycles that are never acknowledged.

Parameters:
- TIMEOUT_CYCLES, 1023: CORE_CLK_INT cycles in REQ state before the bridge force-completes the cycle.
- MIN_WAIT, 0: extra CORE_CLK_INT cycles READY_IN stays low after MEM_ACK.

Ports:
- CORE_CLK_INT  in  1  core clock; all logic rising-edge.
- RESET_INT  in  1  reset, asynchronous, active-high.
- ALE  in  1  address latch enable from core.
- RD_n  in  1  read strobe, active-low.
- WR_n  in  1  write strobe, active-low.
- INTA_n  in  1  interrupt acknowledge strobe, active-low.
- IOM  in  1  1 = IO cycle, 0 = memory cycle.
- AD_OUT  in  20  multiplexed address/data from core.
- AD_IN  out  8  read data/vector to core.
- READY_IN  out  1  ready to core.
- INTA_VECTOR  in  8  vector returned on INTA cycles.
- MEM_REQ  out  1  request valid.
- MEM_WE  out  1  1 = write.
- MEM_IO  out  1  1 = IO space.
- MEM_ADDR  out  20  latched address; bits 19:16 forced to 0 when MEM_IO = 1.
- MEM_WDATA  out  8  write data.
- MEM_ACK  in  1  one-cycle completion pulse from fabric.
- MEM_RDATA  in  8  read data, valid with MEM_ACK.
- BUS_TIMEOUT  out  1  one-cycle pulse on forced completion.
- PROTO_ERR  out  1  one-cycle pulse on illegal strobe combination.

Behaviour:
- Reset values: AD_IN = 8'hFF, READY_IN = 1, MEM_REQ = 0, MEM_WE = 0, MEM_IO = 0, MEM_ADDR = 0, MEM_WDATA = 0, BUS_TIMEOUT = 0, PROTO_ERR = 0. State = IDLE.
- Reset asserted mid-cycle: all outputs return to reset values immediately. No request is reissued after reset.
- Strobe = any of RD_n, WR_n or INTA_n low. All strobe tests are on registered samples.
- IDLE:
  - On ALE = 1, latch AD_OUT[19:0] and IOM; go to ADDR.
  - Strobes are ignored in IDLE.
- ADDR:
  - Further ALE re-latches the address.
  - RD_n and WR_n both low: pulse PROTO_ERR, return to IDLE.
  - Exactly one strobe low: READY_IN = 0 the next cycle.
    - INTA_n: go to HOLD with AD_IN = INTA_VECTOR. No fabric request; READY_IN returns to 1 after MIN_WAIT.
    - RD_n or WR_n: go to REQ with MEM_REQ = 1 and MEM_WE = !WR_n. For writes, MEM_WDATA = AD_OUT[7:0] sampled in the same cycle.
- REQ:
  - MEM_REQ and MEM_ADDR/MEM_WE/MEM_IO/MEM_WDATA are held stable until MEM_ACK.
  - On MEM_ACK: MEM_REQ = 0 the next cycle; on reads, AD_IN = MEM_RDATA; go to WAITST.
  - Timeout counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry and increments per cycle. Reaching TIMEOUT_CYCLES without ACK: drop MEM_REQ, pulse BUS_TIMEOUT, AD_IN = 8'hFF for reads, go to WAITST.
  - ALE or a new strobe while in REQ: pulse PROTO_ERR, otherwise ignored.
- WAITST: count MIN_WAIT cycles (0 = skip), then READY_IN = 1, go to HOLD.
- HOLD:
  - AD_IN holds its value while the strobe stays low.
  - When all strobes are high: AD_IN = 8'hFF, go to IDLE. If ALE is also high in that cycle, latch the address and go to ADDR directly.
- MEM_ACK outside REQ is ignored.
- Latency: strobe low to MEM_REQ high = 1 cycle. MEM_ACK to READY_IN high = 1 + MIN_WAIT cycles.

Test Plan:
- Memory read: ALE with AD_OUT = 20'hF_FFF0, RD_n low, ACK after 3 cycles with RDATA = 8'hEA -> MEM_ADDR = 20'hFFFF0, MEM_WE = 0, READY_IN low for 4 cycles, AD_IN = 8'hEA until RD_n high, then 8'hFF.
- IO write: IOM = 1, AD_OUT = 20'hA_0060, WR_n low with AD_OUT[7:0] = 8'h5A -> MEM_IO = 1, MEM_ADDR = 20'h00060, MEM_WDATA = 8'h5A, MEM_WE = 1.
- INTA cycle: INTA_VECTOR = 8'h08, INTA_n low -> no MEM_REQ, AD_IN = 8'h08, READY_IN back high after MIN_WAIT.
- Timeout: TIMEOUT_CYCLES = 16, read with no ACK -> MEM_REQ drops after 16 cycles, BUS_TIMEOUT pulses once, AD_IN = 8'hFF, READY_IN = 1.
- Protocol error: RD_n and WR_n both low in ADDR -> PROTO_ERR pulse, no MEM_REQ.
- Reset during REQ: RESET_INT pulsed while MEM_REQ = 1 -> MEM_REQ = 0 and READY_IN = 1 asynchronously; a late MEM_ACK is ignored.

Source files
------------

// File: rtl/mcl86_bus_bridge.sv
// Bridges the multiplexed 8088 minimum-mode bus onto a single-beat req/ack fabric.
// Handles address latching, read/write/INTA cycles, wait-state pacing and timeouts.
`timescale 1ns/1ps
module mcl86_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned MIN_WAIT       = 0
) (
    input  logic        CORE_CLK_INT,
    input  logic        RESET_INT,
    input  logic        ALE,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        INTA_n,
    input  logic        IOM,
    input  logic [19:0] AD_OUT,
    output logic [7:0]  AD_IN,
    output logic        READY_IN,
    input  logic [7:0]  INTA_VECTOR,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic        MEM_IO,
    output logic [19:0] MEM_ADDR,
    output logic [7:0]  MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [7:0]  MEM_RDATA,
    output logic        BUS_TIMEOUT,
    output logic        PROTO_ERR
);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned WT_W = (MIN_WAIT > 0) ? $clog2(MIN_WAIT + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_REQ, S_WAITST, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [7:0]        ad_in_q, ad_in_d;
    logic              ready_q, ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_io_q, mem_io_d;
    logic [19:0]       mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              bus_timeout_q, bus_timeout_d;
    logic              proto_err_q, proto_err_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [WT_W-1:0]   wt_cnt_q, wt_cnt_d;
    logic [2:0]        strb_prev_q, strb_prev_d;

    logic [2:0]        strb;
    logic              any_low, one_low, multi_low, new_strobe;
    logic [19:0]       latch_addr;

    assign strb       = {RD_n, WR_n, INTA_n};
    assign any_low    = ~&strb;
    assign one_low    = ($countones(~strb) == 1);
    assign multi_low  = any_low && !one_low;
    assign new_strobe = |(strb_prev_q & ~strb);
    // IO space only decodes 16 address bits
    assign latch_addr = {IOM ? 4'h0 : AD_OUT[19:16], AD_OUT[15:0]};

    always_ff @(posedge CORE_CLK_INT or posedge RESET_INT) begin
        if (RESET_INT) begin
            state_q       <= S_IDLE;
            ad_in_q       <= 8'hFF;
            ready_q       <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_io_q      <= 1'b0;
            mem_addr_q    <= 20'h0;
            mem_wdata_q   <= 8'h0;
            bus_timeout_q <= 1'b0;
            proto_err_q   <= 1'b0;
            to_cnt_q      <= '0;
            wt_cnt_q      <= '0;
            strb_prev_q   <= 3'b111;
        end else begin
            state_q       <= state_d;
            ad_in_q       <= ad_in_d;
            ready_q       <= ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_io_q      <= mem_io_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            bus_timeout_q <= bus_timeout_d;
            proto_err_q   <= proto_err_d;
            to_cnt_q      <= to_cnt_d;
            wt_cnt_q      <= wt_cnt_d;
            strb_prev_q   <= strb_prev_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ad_in_d       = ad_in_q;
        ready_d       = ready_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_io_d      = mem_io_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        bus_timeout_d = 1'b0;
        proto_err_d   = 1'b0;
        to_cnt_d      = to_cnt_q;
        wt_cnt_d      = wt_cnt_q;
        strb_prev_d   = strb;

        case (state_q)
            S_IDLE: begin
                if (ALE) begin
                    mem_addr_d = latch_addr;
                    mem_io_d   = IOM;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (multi_low) begin
                    proto_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (one_low) begin
                    ready_d = 1'b0;
                    if (!INTA_n) begin
                        ad_in_d  = INTA_VECTOR;
                        wt_cnt_d = '0;
                        state_d  = S_HOLD;
                    end else begin
                        mem_req_d = 1'b1;
                        mem_we_d  = !WR_n;
                        if (!WR_n) mem_wdata_d = AD_OUT[7:0];
                        to_cnt_d  = '0;
                        state_d   = S_REQ;
                    end
                end else if (ALE) begin
                    mem_addr_d = latch_addr;
                    mem_io_d   = IOM;
                end
            end
            S_REQ: begin
                if (ALE || new_strobe) proto_err_d = 1'b1;
                if (MEM_ACK) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) ad_in_d = MEM_RDATA;
                    wt_cnt_d  = '0;
                    state_d   = S_WAITST;
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_req_d     = 1'b0;
                    bus_timeout_d = 1'b1;
                    if (!mem_we_q) ad_in_d = 8'hFF;
                    wt_cnt_d      = '0;
                    state_d       = S_WAITST;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WAITST: begin
                if (wt_cnt_q == WT_W'(MIN_WAIT)) begin
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    wt_cnt_d = wt_cnt_q + WT_W'(1);
                end
            end
            S_HOLD: begin
                // INTA cycles arrive here with READY still low and pace it here
                if (!ready_q) begin
                    if (wt_cnt_q == WT_W'(MIN_WAIT)) ready_d = 1'b1;
                    else wt_cnt_d = wt_cnt_q + WT_W'(1);
                end
                if (!any_low) begin
                    ad_in_d = 8'hFF;
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                    if (ALE) begin
                        mem_addr_d = latch_addr;
                        mem_io_d   = IOM;
                        state_d    = S_ADDR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign AD_IN       = ad_in_q;
    assign READY_IN    = ready_q;
    assign MEM_REQ     = mem_req_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_IO      = mem_io_q;
    assign MEM_ADDR    = mem_addr_q;
    assign MEM_WDATA   = mem_wdata_q;
    assign BUS_TIMEOUT = bus_timeout_q;
    assign PROTO_ERR   = proto_err_q;
endmodule

// File: tb/tb_mcl86_bus_bridge.sv
// Directed bench for mcl86_bus_bridge; fabric requests are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_mcl86_bus_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        ale, rd_n, wr_n, inta_n, iom;
    logic [19:0] ad_out;
    logic [7:0]  ad_in;
    logic        ready_in;
    logic [7:0]  inta_vector;
    logic        mem_req, mem_we, mem_io;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        bus_timeout, proto_err;

    typedef struct packed {
        logic [19:0] addr;
        logic        we;
        logic        io;
        logic [7:0]  wdata;
    } req_t;

    req_t req_q[$];
    int   total = 0;
    int   bad   = 0;
    logic req_prev = 1'b0;

    always #5 clk = ~clk;

    mcl86_bus_bridge #(.TIMEOUT_CYCLES(16), .MIN_WAIT(0)) dut (
        .CORE_CLK_INT(clk), .RESET_INT(rst), .ALE(ale), .RD_n(rd_n), .WR_n(wr_n),
        .INTA_n(inta_n), .IOM(iom), .AD_OUT(ad_out), .AD_IN(ad_in), .READY_IN(ready_in),
        .INTA_VECTOR(inta_vector), .MEM_REQ(mem_req), .MEM_WE(mem_we), .MEM_IO(mem_io),
        .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_ACK(mem_ack), .MEM_RDATA(mem_rdata),
        .BUS_TIMEOUT(bus_timeout), .PROTO_ERR(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and score any newly raised fabric request.
    task automatic step();
        req_t e;
        @(posedge clk);
        #1;
        if (mem_req && !req_prev) begin
            if (req_q.size() == 0) begin
                chk("unexpected_req", 32'(mem_addr), 32'hFFFFFFFF);
            end else begin
                e = req_q.pop_front();
                chk("sb_addr", 32'(mem_addr), 32'(e.addr));
                chk("sb_we", 32'(mem_we), 32'(e.we));
                chk("sb_io", 32'(mem_io), 32'(e.io));
                if (e.we) chk("sb_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
        end
        req_prev = mem_req;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int to_pulses;
        rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1; iom = 1'b0;
        ad_out = 20'h0; inta_vector = 8'h0; mem_ack = 1'b0; mem_rdata = 8'h0;
        step(); step();
        chk("rst_ad_in", 32'(ad_in), 32'hFF);
        chk("rst_ready", 32'(ready_in), 32'h1);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_io", 32'(mem_io), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_to", 32'(bus_timeout), 32'h0);
        chk("rst_pe", 32'(proto_err), 32'h0);
        rst = 1'b0;
        step();

        // memory read, ACK three cycles after request
        ale = 1'b1; ad_out = 20'hFFFF0; iom = 1'b0;
        step();
        ale = 1'b0; rd_n = 1'b0;
        req_q.push_back('{addr: 20'hFFFF0, we: 1'b0, io: 1'b0, wdata: 8'h00});
        step();
        chk("rd_req_lat", 32'(mem_req), 32'h1);
        chk("rd_ready_c0", 32'(ready_in), 32'h0);
        step();
        chk("rd_ready_c1", 32'(ready_in), 32'h0);
        step();
        chk("rd_ready_c2", 32'(ready_in), 32'h0);
        chk("rd_req_held", 32'(mem_req), 32'h1);
        mem_ack = 1'b1; mem_rdata = 8'hEA;
        step();
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk("rd_req_drop", 32'(mem_req), 32'h0);
        chk("rd_ready_c3", 32'(ready_in), 32'h0);
        chk("rd_data", 32'(ad_in), 32'hEA);
        step();
        chk("rd_ready_up", 32'(ready_in), 32'h1);
        step();
        chk("rd_data_hold", 32'(ad_in), 32'hEA);
        rd_n = 1'b1;
        step();
        chk("rd_data_ff", 32'(ad_in), 32'hFF);

        // IO write; address bits 19:16 must be masked
        ale = 1'b1; iom = 1'b1; ad_out = 20'hA0060;
        step();
        chk("io_addr", 32'(mem_addr), 32'h00060);
        chk("io_flag", 32'(mem_io), 32'h1);
        ale = 1'b0; wr_n = 1'b0; ad_out = 20'h0005A;
        req_q.push_back('{addr: 20'h00060, we: 1'b1, io: 1'b1, wdata: 8'h5A});
        step();
        chk("wr_req", 32'(mem_req), 32'h1);
        ad_out = 20'h00000;
        step(); step();
        chk("wr_wdata_held", 32'(mem_wdata), 32'h5A);
        chk("wr_req_held", 32'(mem_req), 32'h1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("wr_req_drop", 32'(mem_req), 32'h0);
        chk("wr_ad_in", 32'(ad_in), 32'hFF);
        step();
        chk("wr_ready_up", 32'(ready_in), 32'h1);
        // strobe release with ALE goes straight to a new address phase
        wr_n = 1'b1; iom = 1'b0; ale = 1'b1; ad_out = 20'h23456;
        step();
        chk("hold_ale_addr", 32'(mem_addr), 32'h23456);
        chk("hold_ale_io", 32'(mem_io), 32'h0);
        ale = 1'b0;
        step();

        // INTA cycle from the pending address phase
        inta_vector = 8'h08; inta_n = 1'b0;
        step();
        chk("inta_vec", 32'(ad_in), 32'h08);
        chk("inta_ready_lo", 32'(ready_in), 32'h0);
        step();
        chk("inta_ready_hi", 32'(ready_in), 32'h1);
        chk("inta_no_req", 32'(mem_req), 32'h0);
        chk("inta_vec_hold", 32'(ad_in), 32'h08);
        inta_n = 1'b1;
        step();
        chk("inta_ff", 32'(ad_in), 32'hFF);

        // read timeout after 16 cycles
        ale = 1'b1; ad_out = 20'h12345;
        step();
        ale = 1'b0; rd_n = 1'b0;
        req_q.push_back('{addr: 20'h12345, we: 1'b0, io: 1'b0, wdata: 8'h00});
        step();
        hi = mem_req ? 1 : 0;
        to_pulses = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            step();
            if (mem_req) hi++;
            if (bus_timeout) to_pulses++;
        end
        chk("to_req_cycles", 32'(hi), 32'd16);
        chk("to_pulse_now", 32'(bus_timeout), 32'h1);
        chk("to_ad_in", 32'(ad_in), 32'hFF);
        step();
        if (bus_timeout) to_pulses++;
        chk("to_pulse_once", 32'(to_pulses), 32'd1);
        chk("to_ready", 32'(ready_in), 32'h1);
        rd_n = 1'b1;
        step();

        // RD and WR together in the address phase
        ale = 1'b1; ad_out = 20'h00100;
        step();
        ale = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        step();
        chk("pe_pulse", 32'(proto_err), 32'h1);
        chk("pe_no_req", 32'(mem_req), 32'h0);
        chk("pe_ready", 32'(ready_in), 32'h1);
        rd_n = 1'b1; wr_n = 1'b1;
        step();
        chk("pe_clear", 32'(proto_err), 32'h0);
        step();

        // ALE during REQ, then reset mid-request
        ale = 1'b1; ad_out = 20'h0ABCD;
        step();
        ale = 1'b0; rd_n = 1'b0;
        req_q.push_back('{addr: 20'h0ABCD, we: 1'b0, io: 1'b0, wdata: 8'h00});
        step();
        ale = 1'b1;
        step();
        ale = 1'b0;
        chk("req_ale_pe", 32'(proto_err), 32'h1);
        chk("req_ale_held", 32'(mem_req), 32'h1);
        chk("req_ale_addr", 32'(mem_addr), 32'h0ABCD);
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(mem_req), 32'h0);
        chk("arst_ready", 32'(ready_in), 32'h1);
        chk("arst_addr", 32'(mem_addr), 32'h0);
        step();
        rst = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 8'h55;
        step();
        mem_ack = 1'b0;
        chk("late_ack_ad_in", 32'(ad_in), 32'hFF);
        chk("late_ack_req", 32'(mem_req), 32'h0);
        step(); step();
        chk("no_reissue", 32'(mem_req), 32'h0);
        rd_n = 1'b1;
        step();
        chk("sb_empty", 32'(req_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
